display_scan_ctrl: RTL and testbench



---
 rtl/display_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_display_scan_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Digit-scan sequencer for a 4-digit 7-segment display: dead-time/on-time slots,
// blink phase generation and per-digit gating (blink, leading-zero blank, dot).
module display_scan_ctrl #(
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 500,
  parameter int BLINK_DIV   = 12500000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Enable,
  input  logic [3:0] i_Blink_Mask,
  input  logic       i_Blank_Leading,
  input  logic [3:0] i_Lead_Digit,
  input  logic       i_Dot_En,
  input  logic       i_Dot_Blink,
  output logic [1:0] o_Select,
  output logic [3:0] o_Enable_Digits,
  output logic       o_Enable_Dot,
  output logic       o_Blink_Phase
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] DEAD_LAST  = SW'(DEAD_CYCLES - 1);
  localparam logic [SW-1:0] ON_LAST    = SW'(SCAN_DIV - DEAD_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  typedef enum logic {S_DEAD = 1'b0, S_ON = 1'b1} state_t;

  state_t        state_q;
  logic [SW-1:0] slot_cnt_q;
  logic [1:0]    select_q;
  logic [3:0]    en_digits_q;
  logic          en_dot_q;
  logic [BW-1:0] blink_cnt_q;
  logic [BW-1:0] blink_cnt_d;
  logic          blink_phase_q;
  logic          blink_phase_d;
  logic [3:0]    digit_onehot_s;
  logic          digit_vis_s;
  logic          dot_vis_s;

  // Blink counter next state; the gating below uses the phase that becomes visible
  // on the same edge so o_Blink_Phase and the enables always agree.
  always_comb begin
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end else begin
      blink_cnt_d   = blink_cnt_q + BW'(1);
      blink_phase_d = blink_phase_q;
    end
  end

  // Visibility of the current slot's digit and of the dot.
  always_comb begin
    digit_onehot_s = 4'b1000 >> select_q;
    digit_vis_s    = ~((|(i_Blink_Mask & digit_onehot_s)) & ~blink_phase_d) &
                     ~((select_q == 2'd0) & i_Blank_Leading & (i_Lead_Digit == 4'd0));
    dot_vis_s      = i_Dot_En & (~i_Dot_Blink | blink_phase_d);
  end

  // Free-running blink phase generator.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  // Scan FSM with registered select and enables.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= S_DEAD;
      slot_cnt_q  <= '0;
      select_q    <= 2'd0;
      en_digits_q <= 4'b0000;
      en_dot_q    <= 1'b0;
    end else if (!i_Enable) begin
      state_q     <= S_DEAD;
      slot_cnt_q  <= '0;
      en_digits_q <= 4'b0000;
      en_dot_q    <= 1'b0;
    end else begin
      case (state_q)
        S_DEAD: begin
          if (slot_cnt_q == DEAD_LAST) begin
            state_q     <= S_ON;
            slot_cnt_q  <= '0;
            en_digits_q <= digit_vis_s ? digit_onehot_s : 4'b0000;
            en_dot_q    <= dot_vis_s;
          end else begin
            slot_cnt_q  <= slot_cnt_q + SW'(1);
            en_digits_q <= 4'b0000;
            en_dot_q    <= 1'b0;
          end
        end
        S_ON: begin
          if (slot_cnt_q == ON_LAST) begin
            // Select advances only together with the enables going dark.
            state_q     <= S_DEAD;
            slot_cnt_q  <= '0;
            select_q    <= select_q + 2'd1;
            en_digits_q <= 4'b0000;
            en_dot_q    <= 1'b0;
          end else begin
            slot_cnt_q  <= slot_cnt_q + SW'(1);
            en_digits_q <= digit_vis_s ? digit_onehot_s : 4'b0000;
            en_dot_q    <= dot_vis_s;
          end
        end
        default: begin
          state_q     <= S_DEAD;
          slot_cnt_q  <= '0;
          en_digits_q <= 4'b0000;
          en_dot_q    <= 1'b0;
        end
      endcase
    end
  end

  assign o_Select        = select_q;
  assign o_Enable_Digits = en_digits_q;
  assign o_Enable_Dot    = en_dot_q;
  assign o_Blink_Phase   = blink_phase_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: a slot-position model checked every cycle,
// plus literal expectations at key points (startup, blank release, enable drop, async reset).
module tb_display_scan_ctrl;

  localparam int SCAN  = 8;
  localparam int DEAD  = 2;
  localparam int BLINK = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] blink_mask = 4'b0000;
  logic       blank = 1'b0;
  logic [3:0] lead = 4'd0;
  logic       dot_en = 1'b0;
  logic       dot_blink = 1'b0;
  logic [1:0] sel;
  logic [3:0] en_digits;
  logic       en_dot;
  logic       phase;

  int vectors = 0;
  int miscompares = 0;

  // Model state: position inside the slot, slot number, edges since reset.
  int         m_pos, m_sel, m_t;
  logic [3:0] m_en;
  logic       m_dot, m_ph;

  display_scan_ctrl #(.SCAN_DIV(SCAN), .DEAD_CYCLES(DEAD), .BLINK_DIV(BLINK)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(enable), .i_Blink_Mask(blink_mask),
    .i_Blank_Leading(blank), .i_Lead_Digit(lead), .i_Dot_En(dot_en),
    .i_Dot_Blink(dot_blink), .o_Select(sel), .o_Enable_Digits(en_digits),
    .o_Enable_Dot(en_dot), .o_Blink_Phase(phase)
  );

  always #5 clk = ~clk;

  function automatic bit phase_at(int t);
    return ((t / BLINK) % 2) == 0;
  endfunction

  function automatic int npos(int p);
    if (!enable) return 0;
    if (p == SCAN - 1) return 0;
    return p + 1;
  endfunction

  function automatic int nsel(int p, int s);
    if (enable && p == SCAN - 1) return (s + 1) % 4;
    return s;
  endfunction

  function automatic logic [3:0] en_at(int p, int s, bit ph);
    logic [3:0] oh;
    oh = 4'b1000 >> s;
    if (p < DEAD) return 4'b0000;
    if (((blink_mask & oh) != 4'b0000) && !ph) return 4'b0000;
    if (s == 0 && blank && lead == 4'd0) return 4'b0000;
    return oh;
  endfunction

  function automatic logic dot_at(int p, bit ph);
    return (p >= DEAD) && dot_en && (!dot_blink || ph);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos <= 0; m_sel <= 0; m_t <= 0;
      m_en <= 4'b0000; m_dot <= 1'b0; m_ph <= 1'b1;
    end else begin
      m_t   <= m_t + 1;
      m_ph  <= phase_at(m_t + 1);
      m_pos <= npos(m_pos);
      m_sel <= nsel(m_pos, m_sel);
      m_en  <= en_at(npos(m_pos), nsel(m_pos, m_sel), phase_at(m_t + 1));
      m_dot <= dot_at(npos(m_pos), phase_at(m_t + 1));
    end
  end

  task automatic tick();
    @(negedge clk);
    vectors++;
    if (sel !== 2'(m_sel) || en_digits !== m_en || en_dot !== m_dot || phase !== m_ph) begin
      miscompares++;
      $display("FAIL cycle t=%0d: got sel=%0d en=%b dot=%b ph=%b expected sel=%0d en=%b dot=%b ph=%b",
               m_t, sel, en_digits, en_dot, phase, m_sel, m_en, m_dot, m_ph);
    end
  endtask

  task automatic lit(string name, logic [3:0] got, logic [3:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic wait_model(int s, int p);
    int n;
    n = 0;
    while (!(m_sel == s && m_pos == p) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_slot: got timeout expected slot %0d pos %0d", s, p);
    end
  endtask

  // Called at a negedge with reset held; releases it and checks the first slot.
  task automatic startup();
    rst_n = 1'b1;
    lit("rst_en", en_digits, 4'b0000);
    lit("rst_sel", {2'b00, sel}, 4'd0);
    lit("rst_ph", {3'b000, phase}, 4'd1);
    for (int k = 1; k <= 8; k++) begin
      tick();
      lit("start_en", en_digits, (k >= 2 && k <= 7) ? 4'b1000 : 4'b0000);
      lit("start_sel", {2'b00, sel}, (k == 8) ? 4'd1 : 4'd0);
      lit("start_ph", {3'b000, phase}, 4'd1);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    startup();

    repeat (40) tick();

    blink_mask = 4'b1000;
    repeat (128) tick();
    blink_mask = 4'b0000;

    blank = 1'b1; lead = 4'd0;
    repeat (16) tick();
    wait_model(0, 4);
    lit("blank_slot0", en_digits, 4'b0000);
    lead = 4'd5;
    tick();
    lit("lead_5", en_digits, 4'b1000);
    blank = 1'b0; lead = 4'd0;

    dot_en = 1'b1; dot_blink = 1'b1;
    repeat (80) tick();
    wait_model(2, 4);
    enable = 1'b0;
    tick();
    lit("dis_en", en_digits, 4'b0000);
    lit("dis_sel", {2'b00, sel}, 4'd2);
    lit("dis_dot", {3'b000, en_dot}, 4'd0);
    repeat (3) tick();
    enable = 1'b1;
    tick();
    lit("reen_dead", en_digits, 4'b0000);
    tick();
    lit("reen_on", en_digits, 4'b0010);
    repeat (20) tick();

    wait_model(3, 4);
    #2 rst_n = 1'b0;
    #1;
    lit("async_en", en_digits, 4'b0000);
    lit("async_sel", {2'b00, sel}, 4'd0);
    lit("async_dot", {3'b000, en_dot}, 4'd0);
    lit("async_ph", {3'b000, phase}, 4'd1);
    dot_en = 1'b0; dot_blink = 1'b0;
    @(negedge clk);
    startup();
    repeat (40) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
